// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Purpose  : Shared types and constants for the HI/LO sequencer: FSM state
//            encoding, default datapath width and the unit-select encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // Default datapath width of operands and HI/LO.
  localparam int DEFAULT_WIDTH = 32;

  // Unit-select encoding latched when a request is accepted.
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl_if
// Purpose  : Bundle of request, unit handshake and HI/LO result signals
//            between the control unit / iterative units and hilo_ctrl.
// Modports : slave  - the sequencer (hilo_ctrl)
//            master - control unit plus divide/multiply units (or a bench)
// Signals  : op_div/op_mult/rs_val/rt_val      request from control unit
//            unit_a/unit_b, *_start            operands and launch to units
//            *_done, div_zero, *_hi/*_lo       results from units
//            busy/ack/div0_exc/timeout         status to control unit
//            hi_out/lo_out                     architectural HI/LO
// Options  : HILO_MOVE_TO_EN adds mthi/mtlo requests.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_ctrl_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Requests from the main control unit.
  logic             op_div;
  logic             op_mult;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
`ifdef HILO_MOVE_TO_EN
  logic             mthi;
  logic             mtlo;
`endif

  // Operands and launch to the iterative units.
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic             div_start;
  logic             mult_start;

  // Results from the iterative units.
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             mult_done;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;

  // Status and architectural state back to the control unit.
  logic             busy;
  logic             ack;
  logic             div0_exc;
  logic             timeout;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport slave (
    input  op_div, op_mult, rs_val, rt_val,
`ifdef HILO_MOVE_TO_EN
    input  mthi, mtlo,
`endif
    input  div_done, div_zero, div_hi, div_lo,
    input  mult_done, mult_hi, mult_lo,
    output unit_a, unit_b, div_start, mult_start,
    output busy, ack, div0_exc, timeout, hi_out, lo_out
  );

  modport master (
    output op_div, op_mult, rs_val, rt_val,
`ifdef HILO_MOVE_TO_EN
    output mthi, mtlo,
`endif
    output div_done, div_zero, div_hi, div_lo,
    output mult_done, mult_hi, mult_lo,
    input  unit_a, unit_b, div_start, mult_start,
    input  busy, ack, div0_exc, timeout, hi_out, lo_out
  );

endinterface : hilo_ctrl_if
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl
// Purpose  : Sequencer between the main control unit and the iterative
//            divide/multiply units. Owns the architectural HI/LO registers,
//            launches the selected unit, waits for its completion under a
//            watchdog, and commits results or reports divide-by-zero/timeout.
// Ports    : clk    - system clock
//            reset  - synchronous, active-high reset
//            bus    - hilo_ctrl_if.slave (requests, unit handshake, HI/LO)
// Params   : WIDTH    - datapath width
//            MAX_WAIT - cycles allowed in WAIT before the watchdog aborts
//            CNT_W    - watchdog counter width, 2**CNT_W > MAX_WAIT
// Options  : HILO_MOVE_TO_EN - when defined, mthi/mtlo in IDLE write rs_val
//            directly into HI/LO and pulse ack.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input wire         clk,
  input wire         reset,
  hilo_ctrl_if.slave bus
);

  // WAIT lasts at most MAX_WAIT cycles: the counter reads 0 in the first
  // WAIT cycle, so the abort decision is taken when it reads MAX_WAIT-1.
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MAX_WAIT - 1);

  state_t           r_state;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_unit_a;
  logic [WIDTH-1:0] r_unit_b;
  logic             r_div_start;
  logic             r_mult_start;
  logic             r_ack;
  logic             r_div0_exc;
  logic             r_timeout;
  logic [WIDTH-1:0] r_stage_hi;
  logic [WIDTH-1:0] r_stage_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Completion and results of whichever unit was launched; the other unit's
  // handshake is never looked at.
  logic             w_done;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_zero;

  always_comb begin
    w_done   = 1'b0;
    w_res_hi = '0;
    w_res_lo = '0;
    w_zero   = 1'b0;
    if (r_sel == SEL_DIV) begin
      w_done   = bus.div_done;
      w_res_hi = bus.div_hi;
      w_res_lo = bus.div_lo;
      w_zero   = bus.div_zero;
    end else begin
      w_done   = bus.mult_done;
      w_res_hi = bus.mult_hi;
      w_res_lo = bus.mult_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= SEL_MULT;
      r_cnt        <= '0;
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_div_start  <= 1'b0;
      r_mult_start <= 1'b0;
      r_ack        <= 1'b0;
      r_div0_exc   <= 1'b0;
      r_timeout    <= 1'b0;
      r_stage_hi   <= '0;
      r_stage_lo   <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      // All status/launch outputs are single-cycle pulses by default.
      r_div_start  <= 1'b0;
      r_mult_start <= 1'b0;
      r_ack        <= 1'b0;
      r_div0_exc   <= 1'b0;
      r_timeout    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.op_div || bus.op_mult) begin
            // Divide wins a simultaneous request; the multiply is dropped.
            r_unit_a     <= bus.rs_val;
            r_unit_b     <= bus.rt_val;
            r_sel        <= bus.op_div ? SEL_DIV : SEL_MULT;
            // Start is registered so it is high exactly during LAUNCH.
            r_div_start  <= bus.op_div;
            r_mult_start <= !bus.op_div;
            r_state      <= LAUNCH;
          end
`ifdef HILO_MOVE_TO_EN
          else if (bus.mthi || bus.mtlo) begin
            if (bus.mthi) begin
              r_hi <= bus.rs_val;
            end
            if (bus.mtlo) begin
              r_lo <= bus.rs_val;
            end
            r_ack <= 1'b1;
          end
`endif
        end

        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end

        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_zero) begin
            r_div0_exc <= 1'b1;
            r_state    <= IDLE;
          end else if (w_done) begin
            r_stage_hi <= w_res_hi;
            r_stage_lo <= w_res_lo;
            // Registered so ack is high for the whole COMMIT cycle.
            r_ack      <= 1'b1;
            r_state    <= COMMIT;
          end else if (r_cnt == c_last_cnt) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end

        COMMIT: begin
          r_hi    <= r_stage_hi;
          r_lo    <= r_stage_lo;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.unit_a     = r_unit_a;
  assign bus.unit_b     = r_unit_b;
  assign bus.div_start  = r_div_start;
  assign bus.mult_start = r_mult_start;
  assign bus.ack        = r_ack;
  assign bus.div0_exc   = r_div0_exc;
  assign bus.timeout    = r_timeout;
  assign bus.hi_out     = r_hi;
  assign bus.lo_out     = r_lo;
  assign bus.busy       = (r_state != IDLE);

endmodule : hilo_ctrl
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_ctrl
// Purpose  : Directed self-checking bench for hilo_ctrl. Plays the control
//            unit and both iterative units by hand through hilo_ctrl_if.
// Options  : HILO_MOVE_TO_EN enables the mthi/mtlo steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n;
  int   starts;

  hilo_ctrl_if #(.WIDTH(32)) bus ();

  hilo_ctrl #(
    .WIDTH    (32),
    .MAX_WAIT (40),
    .CNT_W    (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.op_div    = 1'b0;
    bus.op_mult   = 1'b0;
    bus.div_done  = 1'b0;
    bus.div_zero  = 1'b0;
    bus.mult_done = 1'b0;
    bus.div_hi    = 32'hDEAD_0001;
    bus.div_lo    = 32'hDEAD_0002;
    bus.mult_hi   = 32'hDEAD_0003;
    bus.mult_lo   = 32'hDEAD_0004;
`ifdef HILO_MOVE_TO_EN
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    chk("rst_unit_a", bus.unit_a, 0);
    chk("rst_starts", {bus.div_start, bus.mult_start, bus.div0_exc, bus.timeout}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // ---------------- divide 100 / 7, done after 33 cycles ----------------
    bus.op_div = 1'b1;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    tick();                                   // LAUNCH
    idle_inputs();
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    starts = 0;
    chk("div_start", bus.div_start, 1);
    chk("div_mult_start", bus.mult_start, 0);
    chk("div_busy", bus.busy, 1);
    chk("div_unit_a", bus.unit_a, 100);
    chk("div_unit_b", bus.unit_b, 7);
    for (int i = 0; i < 32; i++) begin
      tick();                                 // WAIT
      starts += int'(bus.div_start);
    end
    chk("div_extra_start", starts, 0);
    bus.div_done = 1'b1;
    bus.div_hi   = 32'd2;
    bus.div_lo   = 32'd14;
    tick();                                   // COMMIT
    idle_inputs();
    chk("div_ack", bus.ack, 1);
    chk("div_hi_before", bus.hi_out, 0);
    tick();                                   // IDLE
    chk("div_ack_drop", bus.ack, 0);
    chk("div_busy_drop", bus.busy, 0);
    chk("div_hi", bus.hi_out, 2);
    chk("div_lo", bus.lo_out, 14);
    chk("div_unit_a_hold", bus.unit_a, 100);

    // ---------------- divide by zero (zero beats done) ----------------
    bus.op_div = 1'b1;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd0;
    tick();                                   // LAUNCH
    idle_inputs();
    tick();                                   // WAIT
    bus.div_zero = 1'b1;
    bus.div_done = 1'b1;
    bus.div_hi   = 32'h55;
    bus.div_lo   = 32'h66;
    tick();                                   // IDLE, exception pulse
    idle_inputs();
    chk("dz_exc", bus.div0_exc, 1);
    chk("dz_ack", bus.ack, 0);
    chk("dz_busy", bus.busy, 0);
    tick();
    chk("dz_exc_drop", bus.div0_exc, 0);
    chk("dz_ack2", bus.ack, 0);
    chk("dz_hilo", {bus.hi_out, bus.lo_out}, {32'd2, 32'd14});

    // ---------------- multiply 0xFFFFFFFF * 2 ----------------
    bus.op_mult = 1'b1;
    bus.rs_val  = 32'hFFFF_FFFF;
    bus.rt_val  = 32'd2;
    tick();                                   // LAUNCH
    idle_inputs();
    chk("mul_start", {bus.mult_start, bus.div_start}, 2'b10);
    chk("mul_unit_a", bus.unit_a, 32'hFFFF_FFFF);
    tick();                                   // WAIT
    bus.div_done = 1'b1;                      // unselected unit: ignored
    bus.div_zero = 1'b1;
    tick();
    idle_inputs();
    chk("mul_ignore", {bus.busy, bus.ack, bus.div0_exc}, 3'b100);
    bus.mult_done = 1'b1;
    bus.mult_hi   = 32'd1;
    bus.mult_lo   = 32'hFFFF_FFFE;
    tick();                                   // COMMIT
    idle_inputs();
    chk("mul_ack", bus.ack, 1);
    tick();
    chk("mul_hilo", {bus.hi_out, bus.lo_out}, {32'd1, 32'hFFFF_FFFE});
    chk("mul_busy_drop", bus.busy, 0);

    // ---------------- simultaneous div+mult, request during WAIT ----------------
    bus.op_div  = 1'b1;
    bus.op_mult = 1'b1;
    bus.rs_val  = 32'd9;
    bus.rt_val  = 32'd3;
    tick();                                   // LAUNCH
    idle_inputs();
    chk("sim_start", {bus.div_start, bus.mult_start}, 2'b10);
    tick();                                   // WAIT
    bus.op_mult = 1'b1;
    bus.rs_val  = 32'd77;
    bus.rt_val  = 32'd88;
    tick();
    idle_inputs();
    chk("sim_ignored", {bus.div_start, bus.mult_start, bus.busy}, 3'b001);
    chk("sim_unit_a", bus.unit_a, 9);
    bus.div_done = 1'b1;
    bus.div_hi   = 32'd0;
    bus.div_lo   = 32'd3;
    tick();                                   // COMMIT
    idle_inputs();
    chk("sim_ack", bus.ack, 1);
    tick();
    chk("sim_ack_once", bus.ack, 0);
    chk("sim_hilo", {bus.hi_out, bus.lo_out}, {32'd0, 32'd3});
    tick();
    chk("sim_idle", {bus.busy, bus.ack, bus.mult_start}, 0);

    // ---------------- watchdog: no done ever ----------------
    bus.op_div = 1'b1;
    bus.rs_val = 32'd1;
    bus.rt_val = 32'd1;
    tick();                                   // LAUNCH
    idle_inputs();
    n = 0;
    while (n < 60 && bus.timeout !== 1'b1) begin
      tick();
      n++;
    end
    // One cycle into WAIT, 40 WAIT cycles, pulse in the following IDLE cycle.
    chk("to_latency", n, 41);
    chk("to_state", {bus.busy, bus.ack, bus.div0_exc}, 0);
    chk("to_hilo", {bus.hi_out, bus.lo_out}, {32'd0, 32'd3});
    tick();
    chk("to_drop", bus.timeout, 0);

    // ---------------- reset mid-WAIT ----------------
    bus.op_mult = 1'b1;
    bus.rs_val  = 32'd3;
    bus.rt_val  = 32'd4;
    tick();                                   // LAUNCH
    idle_inputs();
    tick();                                   // WAIT
    tick();
    chk("rw_busy_before", bus.busy, 1);
    bus.mult_done = 1'b1;
    bus.mult_hi   = 32'd55;
    bus.mult_lo   = 32'd66;
    reset = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("rw_busy", bus.busy, 0);
    chk("rw_outs", {bus.ack, bus.div0_exc, bus.timeout, bus.mult_start}, 0);
    chk("rw_hilo", {bus.hi_out, bus.lo_out}, 0);
    chk("rw_unit_a", bus.unit_a, 0);
    tick();
    chk("rw_no_commit", {bus.ack, bus.busy}, 0);
    chk("rw_hilo2", {bus.hi_out, bus.lo_out}, 0);

`ifdef HILO_MOVE_TO_EN
    // ---------------- mthi / mtlo ----------------
    bus.mthi   = 1'b1;
    bus.rs_val = 32'hABCD;
    tick();
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b1;
    bus.rs_val = 32'h1234;
    chk("mthi_ack", bus.ack, 1);
    chk("mthi_hi", bus.hi_out, 32'hABCD);
    chk("mthi_busy", bus.busy, 0);
    tick();
    idle_inputs();
    chk("mtlo_ack", bus.ack, 1);
    chk("mtlo_hilo", {bus.hi_out, bus.lo_out}, {32'hABCD, 32'h1234});
    tick();
    chk("mt_ack_drop", bus.ack, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hilo_ctrl
`default_nettype wire

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequencer between the main control unit and the iterative divide/multiply units; owns the architectural HI/LO registers.
- Accepts a one-cycle DIV/MULT request, registers the operands, and pulses start to the selected unit.
- Waits for that unit's done, commits its HI/LO results, and reports completion or a divide-by-zero exception.
- Drives busy so the control unit can stall mfhi/mflo and any new mult/div while an operation is in flight.

Parameters:
- WIDTH, 32, datapath width of operands and HI/LO.
- MAX_WAIT, 40, cycles allowed in WAIT before timeout abort.
- CNT_W, 6, width of wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_div  in  1  one-cycle divide request, sampled only in IDLE.
- op_mult  in  1  one-cycle multiply request, sampled only in IDLE.
- rs_val  in  WIDTH  operand A (dividend / multiplicand).
- rt_val  in  WIDTH  operand B (divisor / multiplier).
- unit_a  out  WIDTH  registered operand A to both units.
- unit_b  out  WIDTH  registered operand B to both units.
- div_start  out  1  one-cycle start pulse to divider.
- div_done  in  1  divider stop_operation.
- div_zero  in  1  divider divide-by-zero flag.
- div_hi, div_lo  in  WIDTH  divider remainder / quotient.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_done  in  1  multiplier done.
- mult_hi, mult_lo  in  WIDTH  product high/low words.
- busy  out  1  high in every state except IDLE.
- ack  out  1  one-cycle pulse when HI/LO are committed.
- div0_exc  out  1  one-cycle pulse on divide by zero.
- timeout  out  1  one-cycle pulse on watchdog abort.
- hi_out, lo_out  out  WIDTH  architectural HI/LO.

Behaviour:
- Reset:
  - All outputs 0, hi_out/lo_out 0, state IDLE, counter 0.
  - Reset asserted mid-operation aborts immediately: no commit, no pulse.
  - Units are reset by the same reset line.
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE:
  - On op_div or op_mult: latch rs_val/rt_val into unit_a/unit_b, latch a sel bit (div=1), go to LAUNCH.
  - Both requests in the same cycle: div has priority, mult is dropped.
  - Requests outside IDLE are ignored.
- LAUNCH:
  - Exactly one cycle; assert div_start or mult_start according to sel.
  - Clear counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If sel=div and div_zero=1: pulse div0_exc next cycle, HI/LO unchanged, go to IDLE. div_zero takes priority over div_done in the same cycle.
  - Else if the selected unit's done=1: capture that unit's hi/lo into internal staging, go to COMMIT.
  - done/zero from the unselected unit is ignored.
  - If counter reaches MAX_WAIT with no done/zero: pulse timeout, HI/LO unchanged, go to IDLE.
- COMMIT:
  - hi_out/lo_out updated at the end of this cycle; ack=1 during this cycle; go to IDLE.
  - Latency from request to ack = 3 + unit latency cycles; new hi_out/lo_out visible the cycle after ack.
- unit_a/unit_b hold their value until the next accepted request.
- busy is combinational from state; it is 0 only in IDLE and never 1 in the cycle after reset.

Optional Feature:
- HILO_MOVE_TO_EN:
  - Defined: adds ports mthi, mtlo (in, 1). In IDLE, mthi writes rs_val to hi_out and mtlo writes rs_val to lo_out on the next edge, ack pulses, no state change.
  - Priority in IDLE: op_div > op_mult > mthi/mtlo. mthi and mtlo may both be asserted in the same cycle and both write.
  - Undefined: ports absent; HI/LO are written only by COMMIT.

Decomposition:
- Shared package hilo_pkg: state enum (IDLE, LAUNCH, WAIT, COMMIT), default WIDTH, and the sel encoding constants SEL_MULT=0, SEL_DIV=1.
- No sub-module; the watchdog counter stays inline.

Test Plan:
- Divide: op_div, rs=100, rt=7, model div_done after 33 cycles -> div_start pulses once; ack; hi_out=2, lo_out=14; busy low again.
- Divide by zero: op_div, rs=5, rt=0, model div_zero=1 -> div0_exc pulses once; hi_out/lo_out keep prior values; no ack.
- Multiply: op_mult, rs=0xFFFFFFFF, rt=2, model product 0x1_FFFFFFFE -> hi_out=1, lo_out=0xFFFFFFFE.
- Simultaneous op_div and op_mult, plus a new request during WAIT -> only div_start fires; the second request is ignored; one ack.
- Reset mid-WAIT, or model never asserts done -> reset returns state to IDLE with all outputs 0; the no-done case gives a timeout pulse at MAX_WAIT=40 with HI/LO unchanged.
- With HILO_MOVE_TO_EN defined: mthi with rs=0xABCD, then mtlo with rs=0x1234 -> hi_out=0xABCD, lo_out=0x1234, one ack each.
